rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, load-return holding FIFO entries (power of two, 2..8).
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-004 stall  input  1  pipeline stall; no register-file write while high.
REQ-005 alu_valid  input  1  ALU/pipeline writeback request this cycle.
REQ-006 alu_wa  input  5  ALU destination register.
REQ-007 alu_wd  input  32  ALU writeback data.
REQ-008 mem_valid  input  1  cache load-return offered.
REQ-009 mem_wa  input  5  load destination register.
REQ-010 mem_wd  input  32  load data.
REQ-011 mem_ready  output  1  load-return accepted when mem_valid && mem_ready.
REQ-012 issue_valid  input  1  load issued to cache this cycle.
REQ-013 issue_rd  input  5  destination of issued load.
REQ-014 raA, raB  input  5 each  decode read addresses for hazard check.
REQ-015 hazard_a, hazard_b  output  1 each  source register awaiting a load return.
REQ-016 rf_wen  output  1  register-file write enable.
REQ-017 rf_wa  output  5  register-file write address.
REQ-018 rf_wd  output  32  register-file write data.

Function
REQ-019 Write-port priority: ALU first, then FIFO head, then direct mem bypass; at most one write per cycle.
REQ-020 rf_wen/rf_wa/rf_wd combinational: same-cycle as the winning source, zero latency.
REQ-021 stall=1: rf_wen=0; FIFO does not pop; pending bits not cleared by writes.
REQ-022 Requests with destination 5'd0 never assert rf_wen; an accepted mem return to r0 is consumed without a write.
REQ-023 Load-return FIFO: in-order, FIFO_DEPTH entries of {wa[4:0], wd[31:0]}; count in 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-024 mem_ready = (count != FIFO_DEPTH); no same-cycle pop credit when full.
REQ-025 Bypass: FIFO empty, alu_valid=0, stall=0, mem_valid=1 -> mem data written directly the same cycle, no push.
REQ-026 Otherwise an accepted mem return is pushed; FIFO head pops when it wins the write port.
REQ-027 Simultaneous push and pop (count not full): count unchanged, order preserved.
REQ-028 Scoreboard: 32-bit pending vector; bit 0 always 0.
REQ-029 issue_valid && issue_rd!=0 sets pending[issue_rd] on the next edge.
REQ-030 A committed load write (FIFO pop or bypass) clears pending[wa] on the next edge.
REQ-031 Set and clear of the same bit in one cycle: set wins.
REQ-032 ALU writes never modify pending bits.
REQ-033 hazard_a = pending[raA]; hazard_b = pending[raB]; combinational from registered state (no same-cycle issue forwarding).
REQ-034 Loads returning to a register with pending=0 still write normally; pending stays 0.

Reset
REQ-035 On reset low: count=0, pointers=0, pending=0; rf_wen=0 and mem_ready=1 (inputs permitting), hazard_a/b=0.
REQ-036 Reset mid-operation discards all FIFO contents and pending bits; no write of discarded entries after release.
REQ-037 First state change only on the first posedge after reset deasserts.

Verification
REQ-038 Bypass: idle, mem_valid wa=5 wd=0xDEADBEEF -> same cycle rf_wen=1, rf_wa=5, rf_wd=0xDEADBEEF, count stays 0.
REQ-039 Conflict: alu_valid wa=3 wd=0x11 with mem_valid wa=7 wd=0x22 -> cycle0 writes r3=0x11, push; next idle cycle writes r7=0x22, count 1->0.
REQ-040 Full: alu_valid held high, 3 mem returns -> first two accepted, third sees mem_ready=0; after alu_valid drops, writes drain in order over 2 cycles.
REQ-041 Scoreboard: issue rd=9, next cycle raA=9 -> hazard_a=1; return wa=9 commits -> hazard_a=0 the cycle after; issue rd=0 -> no hazard.
REQ-042 Stall: FIFO count 1, stall=1 for 3 cycles -> rf_wen=0, count held 1, pending held; stall=0 -> head written.
REQ-043 Reset mid-op: FIFO count 2, pending[4]=1, reset low -> count 0, hazards 0, mem_ready 1, no later writes of old entries.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback-arbiter bus: ALU writeback, cache load-return handshake, load issue,
// decode hazard lookup and the single register-file write port.
interface rf_wb_arbiter_if;
  logic        stall;

  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;

  logic        mem_valid;
  logic [4:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_ready;

  logic        issue_valid;
  logic [4:0]  issue_rd;

  logic [4:0]  raA;
  logic [4:0]  raB;
  logic        hazard_a;
  logic        hazard_b;

  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  // Pipeline / cache side driving the arbiter.
  modport master (
    output stall,
    output alu_valid, alu_wa, alu_wd,
    output mem_valid, mem_wa, mem_wd,
    input  mem_ready,
    output issue_valid, issue_rd,
    output raA, raB,
    input  hazard_a, hazard_b,
    input  rf_wen, rf_wa, rf_wd
  );

  // Arbiter view.
  modport slave (
    input  stall,
    input  alu_valid, alu_wa, alu_wd,
    input  mem_valid, mem_wa, mem_wd,
    output mem_ready,
    input  issue_valid, issue_rd,
    input  raA, raB,
    output hazard_a, hazard_b,
    output rf_wen, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU > load FIFO head > direct load bypass,
// with an in-order load-return FIFO and a pending-load scoreboard for hazards.
module rf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic           clock,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } entry_t;

  typedef enum logic [1:0] {
    SrcNone,
    SrcAlu,
    SrcFifo,
    SrcBypass
  } src_e;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [31:0]        pending_q, pending_d;

  src_e               src;
  entry_t             head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               mem_accept;
  logic               push;
  logic               pop;
  logic               load_commit;
  logic [4:0]         load_wa;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);

  // A full FIFO refuses returns even if the head pops this cycle.
  assign bus.mem_ready = ~fifo_full;
  assign mem_accept    = bus.mem_valid & ~fifo_full;

  always_comb begin
    src = SrcNone;
    if (!bus.stall) begin
      if (bus.alu_valid) begin
        src = SrcAlu;
      end else if (!fifo_empty) begin
        src = SrcFifo;
      end else if (bus.mem_valid) begin
        src = SrcBypass;
      end
    end
  end

  always_comb begin
    bus.rf_wen = 1'b0;
    bus.rf_wa  = 5'd0;
    bus.rf_wd  = 32'd0;
    unique case (src)
      SrcAlu: begin
        bus.rf_wa = bus.alu_wa;
        bus.rf_wd = bus.alu_wd;
      end
      SrcFifo: begin
        bus.rf_wa = head.wa;
        bus.rf_wd = head.wd;
      end
      SrcBypass: begin
        bus.rf_wa = bus.mem_wa;
        bus.rf_wd = bus.mem_wd;
      end
      default: ;
    endcase
    // r0 is never written; the winning request is still consumed.
    bus.rf_wen = (src != SrcNone) && (bus.rf_wa != 5'd0);
  end

  assign pop         = (src == SrcFifo);
  assign push        = mem_accept & (src != SrcBypass);
  assign load_commit = pop | (src == SrcBypass);
  assign load_wa     = pop ? head.wa : bus.mem_wa;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear first so a same-cycle issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (load_commit) begin
      pending_d[load_wa] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign bus.hazard_a = pending_q[bus.raA];
  assign bus.hazard_b = pending_q[bus.raB];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{wa: bus.mem_wa, wd: bus.mem_wd};
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter checked against a queue-based model of the
// writeback priority, load-return FIFO and pending-load scoreboard.
module tb_rf_wb_arbiter;

  localparam int unsigned Depth = 2;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: pending loads in return order, and which registers await one.
  ent_t      mq[$];
  bit [31:0] mpend;

  // Per-cycle expectations computed before the edge.
  logic        e_wen;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic        e_ready;
  bit          m_pop;
  bit          m_byp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.stall       = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.alu_wa      = 5'd0;
    bus.alu_wd      = 32'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_wa      = 5'd0;
    bus.mem_wd      = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.raA         = 5'd0;
    bus.raB         = 5'd0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic        s_mem_valid;
    logic [4:0]  s_mem_wa;
    logic [31:0] s_mem_wd;
    logic        s_issue;
    logic [4:0]  s_rd;
    #1;
    e_ready = (mq.size() != Depth);
    m_pop   = 0;
    m_byp   = 0;
    e_wen   = 1'b0;
    e_wa    = 5'd0;
    e_wd    = 32'd0;
    if (!bus.stall) begin
      if (bus.alu_valid) begin
        e_wa = bus.alu_wa;
        e_wd = bus.alu_wd;
        e_wen = (e_wa != 0);
      end else if (mq.size() > 0) begin
        m_pop = 1;
        e_wa  = mq[0].wa;
        e_wd  = mq[0].wd;
        e_wen = (e_wa != 0);
      end else if (bus.mem_valid) begin
        m_byp = 1;
        e_wa  = bus.mem_wa;
        e_wd  = bus.mem_wd;
        e_wen = (e_wa != 0);
      end
    end
    check("rf_wen", 32'(bus.rf_wen), 32'(e_wen));
    if (e_wen) begin
      check("rf_wa", 32'(bus.rf_wa), 32'(e_wa));
      check("rf_wd", bus.rf_wd, e_wd);
    end
    check("mem_ready", 32'(bus.mem_ready), 32'(e_ready));
    check("hazard_a", 32'(bus.hazard_a), 32'(mpend[bus.raA]));
    check("hazard_b", 32'(bus.hazard_b), 32'(mpend[bus.raB]));
    s_mem_valid = bus.mem_valid;
    s_mem_wa    = bus.mem_wa;
    s_mem_wd    = bus.mem_wd;
    s_issue     = bus.issue_valid;
    s_rd        = bus.issue_rd;
    @(posedge clock);
    if (m_pop) begin
      mpend[mq[0].wa] = 1'b0;
      void'(mq.pop_front());
    end
    if (m_byp) mpend[s_mem_wa] = 1'b0;
    if (s_mem_valid && e_ready && !m_byp) mq.push_back('{wa: s_mem_wa, wd: s_mem_wd});
    if (s_issue && s_rd != 0) mpend[s_rd] = 1'b1;
    mpend[0] = 1'b0;
    @(negedge clock);
  endtask

  // Asynchronous reset asserted away from the clock edge, held over one edge.
  task automatic mid_reset();
    idle();
    bus.raA = 5'd4;
    bus.raB = 5'd9;
    reset = 1'b0;
    #1;
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst_hazard_a", 32'(bus.hazard_a), 32'd0);
    check("rst_hazard_b", 32'(bus.hazard_b), 32'd0);
    check("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
    mq.delete();
    mpend = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mpend   = '0;
    idle();
    reset = 1'b0;
    #12;
    check("init_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("init_rf_wen", 32'(bus.rf_wen), 32'd0);
    check("init_hazard_a", 32'(bus.hazard_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Bypass into an idle arbiter.
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd5; bus.mem_wd = 32'hDEAD_BEEF;
    #1;
    check("byp_wen", 32'(bus.rf_wen), 32'd1);
    check("byp_wa", 32'(bus.rf_wa), 32'd5);
    check("byp_wd", bus.rf_wd, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();

    // ALU wins, load return queued then written on the next idle cycle.
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd3; bus.alu_wd = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd7; bus.mem_wd = 32'h22;
    #1;
    check("conf_alu_wa", 32'(bus.rf_wa), 32'd3);
    tick();
    idle();
    #1;
    check("conf_fifo_wa", 32'(bus.rf_wa), 32'd7);
    check("conf_fifo_wd", bus.rf_wd, 32'h22);
    tick();
    tick();

    // Fill the FIFO behind a busy ALU, then drain in order.
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd1; bus.alu_wd = 32'h1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_valid = 1'b1; bus.mem_wa = 5'(20 + i); bus.mem_wd = 32'(32'hA0 + i);
      if (i == 2) begin
        #1;
        check("full_not_ready", 32'(bus.mem_ready), 32'd0);
      end
      tick();
    end
    idle();
    #1;
    check("drain0_wa", 32'(bus.rf_wa), 32'd20);
    tick();
    #1;
    check("drain1_wa", 32'(bus.rf_wa), 32'd21);
    tick();
    tick();

    // Scoreboard set, hazard visible next cycle, cleared after the load commits.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle();
    bus.raA = 5'd9;
    #1;
    check("sb_set", 32'(bus.hazard_a), 32'd1);
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd9; bus.mem_wd = 32'h99;
    tick();
    idle();
    bus.raA = 5'd9;
    #1;
    check("sb_clear", 32'(bus.hazard_a), 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    tick();
    idle();
    bus.raA = 5'd0;
    tick();

    // Stall holds the queued load and its pending bit.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd2; bus.alu_wd = 32'h2;
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd12; bus.mem_wd = 32'hC0C0;
    tick();
    idle();
    bus.stall = 1'b1;
    bus.raA   = 5'd12;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_wen", 32'(bus.rf_wen), 32'd0);
      check("stall_pend", 32'(bus.hazard_a), 32'd1);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    check("unstall_wa", 32'(bus.rf_wa), 32'd12);
    tick();
    idle();
    tick();

    // Reset with two queued loads and a pending bit; nothing old may be written.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_wa = 5'd8; bus.alu_wd = 32'h8;
    bus.mem_valid = 1'b1; bus.mem_wa = 5'd4; bus.mem_wd = 32'h44;
    tick();
    bus.mem_wa = 5'd6; bus.mem_wd = 32'h66;
    tick();
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      tick();
    end

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 3000; c++) begin
      bus.stall       = ($urandom_range(0, 9) == 0);
      bus.alu_valid   = ($urandom_range(0, 2) == 0);
      bus.alu_wa      = 5'($urandom_range(0, 7));
      bus.alu_wd      = $urandom;
      bus.mem_valid   = ($urandom_range(0, 1) == 0);
      bus.mem_wa      = 5'($urandom_range(0, 7));
      bus.mem_wd      = $urandom;
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.raA         = 5'($urandom_range(0, 7));
      bus.raB         = 5'($urandom_range(0, 7));
      tick();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
